stopwatch_ctrl: RTL and testbench

//  Sequencing controller for a chain of cascaded BCD digit counters (stopwatch/timer).

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/stopwatch_ctrl_if.sv | 32 +++
 rtl/tick_prescaler.sv | 37 +++
 rtl/stopwatch_ctrl.sv | 129 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and sizing helpers for the stopwatch controller
//
// Purpose : FSM state encoding plus divider/width helpers used by
//           stopwatch_ctrl and tick_prescaler.
// Ports   : none (package)
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    FULL  = 2'd3
  } sw_state_t;

  // Clock cycles per lowest-digit count; CLK_HZ must be an integer multiple
  // of TICK_HZ and the result at least 2.
  function automatic int sw_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Prescaler counter width for a given divider.
  function automatic int sw_cnt_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - command/status bundle between buttons, controller and digit chain
//
// Purpose : groups the button pulses, chain status and chain control lines.
// Signals : start_stop, clear, lap  - one-cycle button pulses (to controller)
//           all_9                   - chain reads all 9s (to controller)
//           cnt_en, cnt_reset       - lowest-digit enable / chain sync reset (from controller)
//           running, full, disp_hold- status (from controller)
// Modports: master - environment side (buttons, digit chain, display)
//           slave  - stopwatch_ctrl side
interface stopwatch_ctrl_if;

  logic start_stop;
  logic clear;
  logic lap;
  logic all_9;
  logic cnt_en;
  logic cnt_reset;
  logic running;
  logic full;
  logic disp_hold;

  modport master (
    output start_stop, clear, lap, all_9,
    input  cnt_en, cnt_reset, running, full, disp_hold
  );

  modport slave (
    input  start_stop, clear, lap, all_9,
    output cnt_en, cnt_reset, running, full, disp_hold
  );

endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - mod-DIV counter producing the count tick
//
// Purpose : counts 0..DIV-1 while not held, wraps to 0, flags the last count.
// Params  : DIV - period in clk cycles (>= 2); CW - counter width
// Ports   : clk   in  system clock
//           reset in  synchronous active-high reset
//           clr   in  synchronous clear to 0 (wins over hold)
//           hold  in  freeze the count (keeps position mid-period)
//           tick  out high for the one cycle the count sits at DIV-1 and is not held
module tick_prescaler
  import stopwatch_pkg::*;
#(
  parameter int DIV = 10,
  parameter int CW  = sw_cnt_w(DIV)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = !hold && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (!hold) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - start/pause/clear sequencer for a cascaded BCD stopwatch chain
//
// Purpose : derives the count tick from clk, gates it with the IDLE/RUN/PAUSE/FULL
//           FSM, drives the chain's lowest-digit enable and sync reset, and stops
//           at all-9s instead of wrapping.
// Params  : CLK_HZ  - system clock frequency
//           TICK_HZ - lowest-digit count rate (CLK_HZ/TICK_HZ integer, >= 2)
// Ports   : clk   in  system clock
//           reset in  synchronous active-high reset
//           sw    slave modport of stopwatch_ctrl_if (buttons, all_9 in;
//                 cnt_en, cnt_reset, running, full, disp_hold out - all registered)
// Config  : STOPWATCH_LAP_EN - when defined, lap toggles disp_hold in RUN/PAUSE;
//           otherwise lap is ignored and disp_hold is tied to 0.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_ctrl_if.slave  sw
);

  localparam int DIV = sw_div(CLK_HZ, TICK_HZ);
  localparam int CW  = sw_cnt_w(DIV);

  sw_state_t state;
  logic      tick;
  logic      cnt_en_q;
  logic      cnt_reset_q;
  logic      running_q;
  logic      full_q;
  logic      disp_hold_q;

  // Prescaler only advances in RUN; PAUSE and FULL freeze it mid-period.
  // It is held at 0 throughout IDLE so a fresh start always runs a full period.
  tick_prescaler #(
    .DIV (DIV),
    .CW  (CW)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (sw.clear || (state == IDLE)),
    .hold  (state != RUN),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt_en_q    <= 1'b0;
      // Held through reset and for the first cycle after it, zeroing the chain.
      cnt_reset_q <= 1'b1;
      running_q   <= 1'b0;
      full_q      <= 1'b0;
      disp_hold_q <= 1'b0;
    end else begin
      cnt_en_q    <= 1'b0;
      cnt_reset_q <= 1'b0;
      if (sw.clear) begin
        state       <= IDLE;
        cnt_reset_q <= 1'b1;
        running_q   <= 1'b0;
        full_q      <= 1'b0;
        disp_hold_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (sw.start_stop) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            // A pause wins over a coincident tick; that count is dropped.
            if (sw.start_stop) begin
              state     <= PAUSE;
              running_q <= 1'b0;
            end else if (tick) begin
              if (sw.all_9) begin
                state     <= FULL;
                running_q <= 1'b0;
                full_q    <= 1'b1;
              end else begin
                cnt_en_q <= 1'b1;
              end
            end
          end
          PAUSE: begin
            if (sw.start_stop) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          FULL: begin
            // Saturated: only clear leaves this state.
          end
          default: begin
            state     <= IDLE;
            running_q <= 1'b0;
            full_q    <= 1'b0;
          end
        endcase
`ifdef STOPWATCH_LAP_EN
        if (sw.lap && ((state == RUN) || (state == PAUSE))) begin
          disp_hold_q <= !disp_hold_q;
        end
`endif
      end
    end
  end

`ifndef STOPWATCH_LAP_EN
  logic unused_lap;
  assign unused_lap = sw.lap;
`endif

  assign sw.cnt_en    = cnt_en_q;
  assign sw.cnt_reset = cnt_reset_q;
  assign sw.running   = running_q;
  assign sw.full      = full_q;
`ifdef STOPWATCH_LAP_EN
  assign sw.disp_hold = disp_hold_q;
`else
  assign sw.disp_hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl with a 4-digit chain model
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = !clk;

  stopwatch_ctrl_if sw_if();

  stopwatch_ctrl #(
    .CLK_HZ  (1000),
    .TICK_HZ (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw_if.slave)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int exp_q[$];

  // Four cascaded BCD digits modelled as a 0..9999 value.
  int   chain = 0;
  logic preload_req = 1'b0;
  int   preload_val = 0;

  logic drv_start = 1'b0;
  logic drv_clear = 1'b0;
  logic drv_lap   = 1'b0;

  assign sw_if.start_stop = drv_start;
  assign sw_if.clear      = drv_clear;
  assign sw_if.lap        = drv_lap;
  assign sw_if.all_9      = (chain == 9999);

`ifdef STOPWATCH_LAP_EN
  logic exp_lap = 1'b1;
`else
  logic exp_lap = 1'b0;
`endif

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload_req)                 chain <= preload_val;
    else if (sw_if.cnt_reset === 1'b1) chain <= 0;
    else if (sw_if.cnt_en === 1'b1)    chain <= (chain == 9999) ? 0 : chain + 1;
  end

  // Scoreboard: expected cnt_en cycles popped as the DUT produces pulses.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0] < cyc) begin
      tests++; fails++;
      $display("FAIL cnt_en_missed: expected pulse at cycle %0d, now cycle %0d", exp_q[0], cyc);
      void'(exp_q.pop_front());
    end
    if (sw_if.cnt_en === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL cnt_en_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (cyc !== e) begin
          fails++;
          $display("FAIL cnt_en_timing: pulse at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
      tests++;
      if (sw_if.cnt_reset !== 1'b0) begin
        fails++;
        $display("FAIL en_reset_overlap: cnt_reset=%b with cnt_en at cycle %0d, expected 0", sw_if.cnt_reset, cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    drv_start = 1'b1; step(1); drv_start = 1'b0;
  endtask

  task automatic pulse_clear();
    drv_clear = 1'b1; step(1); drv_clear = 1'b0;
  endtask

  task automatic pulse_lap();
    drv_lap = 1'b1; step(1); drv_lap = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    tests++; if (sw_if.cnt_reset !== 1'b1) begin fails++; $display("FAIL reset_cnt_reset: got %b expected 1", sw_if.cnt_reset); end
    tests++; if (sw_if.cnt_en !== 1'b0) begin fails++; $display("FAIL reset_cnt_en: got %b expected 0", sw_if.cnt_en); end
    tests++; if (sw_if.running !== 1'b0) begin fails++; $display("FAIL reset_running: got %b expected 0", sw_if.running); end
    tests++; if (sw_if.full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", sw_if.full); end
    tests++; if (sw_if.disp_hold !== 1'b0) begin fails++; $display("FAIL reset_disp_hold: got %b expected 0", sw_if.disp_hold); end
    tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected IDLE", dut.state); end
    step(1);
    tests++; if (sw_if.cnt_reset !== 1'b0) begin fails++; $display("FAIL reset_pulse_width: cnt_reset=%b expected 0", sw_if.cnt_reset); end
    tests++; if (chain !== 0) begin fails++; $display("FAIL reset_chain: got %0d expected 0", chain); end
  endtask

  task automatic test_run();
    int s;
    pulse_start();
    s = cyc;
    exp_q.push_back(s + 10); exp_q.push_back(s + 20); exp_q.push_back(s + 30);
    tests++; if (sw_if.running !== 1'b1) begin fails++; $display("FAIL run_running: got %b expected 1", sw_if.running); end
    step(31);
    tests++; if (chain !== 3) begin fails++; $display("FAIL run_chain: got %0d expected 3", chain); end
    pulse_clear();
    tests++; if (sw_if.cnt_reset !== 1'b1) begin fails++; $display("FAIL run_clear_pulse: got %b expected 1", sw_if.cnt_reset); end
    step(1);
  endtask

  task automatic test_pause();
    int s, r;
    pulse_start();
    s = cyc;
    exp_q.push_back(s + 10); exp_q.push_back(s + 20);
    step(24);
    pulse_start();
    tests++; if (sw_if.running !== 1'b0) begin fails++; $display("FAIL pause_running: got %b expected 0", sw_if.running); end
    tests++; if (dut.state !== PAUSE) begin fails++; $display("FAIL pause_state: got %0d expected PAUSE", dut.state); end
    step(100);
    tests++; if (chain !== 2) begin fails++; $display("FAIL pause_chain: got %0d expected 2", chain); end
    pulse_start();
    r = cyc;
    exp_q.push_back(r + 5);
    tests++; if (sw_if.running !== 1'b1) begin fails++; $display("FAIL resume_running: got %b expected 1", sw_if.running); end
    step(6);
    tests++; if (chain !== 3) begin fails++; $display("FAIL resume_chain: got %0d expected 3", chain); end
    pulse_clear();
    step(1);
  endtask

  task automatic test_full();
    int s;
    preload_val = 9998; preload_req = 1'b1; step(1); preload_req = 1'b0;
    tests++; if (chain !== 9998) begin fails++; $display("FAIL full_preload: got %0d expected 9998", chain); end
    pulse_start();
    s = cyc;
    exp_q.push_back(s + 10);
    step(19);
    tests++; if (sw_if.full !== 1'b0) begin fails++; $display("FAIL full_early: got %b expected 0", sw_if.full); end
    tests++; if (chain !== 9999) begin fails++; $display("FAIL full_chain: got %0d expected 9999", chain); end
    step(1);
    tests++; if (sw_if.full !== 1'b1) begin fails++; $display("FAIL full_flag: got %b expected 1", sw_if.full); end
    tests++; if (sw_if.running !== 1'b0) begin fails++; $display("FAIL full_running: got %b expected 0", sw_if.running); end
    tests++; if (dut.state !== FULL) begin fails++; $display("FAIL full_state: got %0d expected FULL", dut.state); end
    step(30);
    pulse_start();
    tests++; if (sw_if.full !== 1'b1) begin fails++; $display("FAIL full_start_ignored: full=%b expected 1", sw_if.full); end
    tests++; if (chain !== 9999) begin fails++; $display("FAIL full_no_wrap: got %0d expected 9999", chain); end
    step(5);
    pulse_clear();
    tests++; if (sw_if.cnt_reset !== 1'b1) begin fails++; $display("FAIL full_clear_pulse: got %b expected 1", sw_if.cnt_reset); end
    tests++; if (sw_if.full !== 1'b0) begin fails++; $display("FAIL full_clear_flag: got %b expected 0", sw_if.full); end
    tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL full_clear_state: got %0d expected IDLE", dut.state); end
    step(1);
    tests++; if (chain !== 0) begin fails++; $display("FAIL full_clear_chain: got %0d expected 0", chain); end
    tests++; if (sw_if.cnt_reset !== 1'b0) begin fails++; $display("FAIL full_clear_width: got %b expected 0", sw_if.cnt_reset); end
  endtask

  task automatic test_coincident();
    int s;
    pulse_start();
    step(5);
    drv_start = 1'b1; drv_clear = 1'b1;
    step(1);
    drv_start = 1'b0; drv_clear = 1'b0;
    tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL coinc_clear_state: got %0d expected IDLE", dut.state); end
    tests++; if (sw_if.cnt_reset !== 1'b1) begin fails++; $display("FAIL coinc_clear_reset: got %b expected 1", sw_if.cnt_reset); end
    tests++; if (sw_if.running !== 1'b0) begin fails++; $display("FAIL coinc_clear_running: got %b expected 0", sw_if.running); end
    step(1);
    pulse_start();
    s = cyc;
    exp_q.push_back(s + 10);
    step(19);
    pulse_start();
    tests++; if (dut.state !== PAUSE) begin fails++; $display("FAIL coinc_tick_state: got %0d expected PAUSE", dut.state); end
    tests++; if (sw_if.cnt_en !== 1'b0) begin fails++; $display("FAIL coinc_tick_en: got %b expected 0", sw_if.cnt_en); end
    step(20);
    tests++; if (chain !== 1) begin fails++; $display("FAIL coinc_tick_chain: got %0d expected 1", chain); end
    pulse_clear();
    step(1);
  endtask

  task automatic test_lap();
    int s;
    pulse_lap();
    tests++; if (sw_if.disp_hold !== 1'b0) begin fails++; $display("FAIL lap_idle: got %b expected 0", sw_if.disp_hold); end
    pulse_start();
    s = cyc;
    exp_q.push_back(s + 10); exp_q.push_back(s + 20);
    step(2);
    pulse_lap();
    tests++; if (sw_if.disp_hold !== exp_lap) begin fails++; $display("FAIL lap_on: got %b expected %b", sw_if.disp_hold, exp_lap); end
    step(8);
    tests++; if (chain !== 1) begin fails++; $display("FAIL lap_counting: got %0d expected 1", chain); end
    pulse_lap();
    tests++; if (sw_if.disp_hold !== 1'b0) begin fails++; $display("FAIL lap_off: got %b expected 0", sw_if.disp_hold); end
    step(9);
    tests++; if (chain !== 2) begin fails++; $display("FAIL lap_counting2: got %0d expected 2", chain); end
    pulse_lap();
    tests++; if (sw_if.disp_hold !== exp_lap) begin fails++; $display("FAIL lap_on2: got %b expected %b", sw_if.disp_hold, exp_lap); end
    pulse_clear();
    tests++; if (sw_if.disp_hold !== 1'b0) begin fails++; $display("FAIL lap_clear: got %b expected 0", sw_if.disp_hold); end
    step(1);
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause();
    test_full();
    test_coincident();
    test_lap();
    step(15);
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d pulses outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
